// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//
// Arbitrates single outstanding DRAM accesses between two requesters:
// requester 0 (CPU data port) and requester 1 (debug loader). A request is
// sampled only in IDLE. Simultaneous requests are resolved round-robin against
// the last granted requester. The granted command is latched and held on the
// DRAM port for the whole access. A watchdog counts BUSY cycles without
// dram_ready and traps the FSM in ERROR on expiry; only reset leaves ERROR.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   en_k, r_nw_k, addr_k,     request k (k = 0,1): enable (held until ready_k),
//   wdata_k                   read/not-write, address, write data
//   ready_k                   one-cycle completion pulse to requester k
//   rdata                     registered read data, valid while ready_k = 1
//   dram_enable, dram_r_nw,   DRAM command port, driven from the latched
//   dram_addr, dram_wdata     command registers
//   dram_rdata, dram_ready    DRAM read data and completion (sampled in BUSY)
//   error                     sticky timeout flag
//   state_debug               current FSM state encoding
// -----------------------------------------------------------------------------
module dram_arbiter #(
  parameter int NUMBIT    = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 16   // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_0,
  input  logic                 r_nw_0,
  input  logic [ADDR_SIZE-1:0] addr_0,
  input  logic [NUMBIT-1:0]    wdata_0,
  input  logic                 en_1,
  input  logic                 r_nw_1,
  input  logic [ADDR_SIZE-1:0] addr_1,
  input  logic [NUMBIT-1:0]    wdata_1,
  output logic                 ready_0,
  output logic                 ready_1,
  output logic [NUMBIT-1:0]    rdata,
  output logic                 dram_enable,
  output logic                 dram_r_nw,
  output logic [ADDR_SIZE-1:0] dram_addr,
  output logic [NUMBIT-1:0]    dram_wdata,
  input  logic [NUMBIT-1:0]    dram_rdata,
  input  logic                 dram_ready,
  output logic                 error,
  output logic [1:0]           state_debug
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]           state;
  logic                 last_grant;   // also identifies the requester being served
  logic [CNT_W-1:0]     cnt;
  logic                 cmd_r_nw;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [NUMBIT-1:0]    cmd_wdata;

  // Grant selection, only acted upon in IDLE.
  logic                 req_any;
  logic                 grant_idx;
  logic                 sel_r_nw;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [NUMBIT-1:0]    sel_wdata;

  // NOTE: every variable assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_any   = en_0 | en_1;
    grant_idx = 1'b0;
    if (en_0 && en_1) begin
      grant_idx = ~last_grant;       // tie: round robin
    end else if (en_1) begin
      grant_idx = 1'b1;
    end
    sel_r_nw  = grant_idx ? r_nw_1  : r_nw_0;
    sel_addr  = grant_idx ? addr_1  : addr_0;
    sel_wdata = grant_idx ? wdata_1 : wdata_0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the command and read-data registers are reset too, so the DRAM port
  // and rdata show defined values from reset instead of X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;            // CPU wins the first tie
      cnt        <= '0;
      cmd_r_nw   <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            state      <= S_BUSY;
            last_grant <= grant_idx;
            cmd_r_nw   <= sel_r_nw;
            cmd_addr   <= sel_addr;
            cmd_wdata  <= sel_wdata;
            cnt        <= '0;
          end
        end
        S_BUSY: begin
          // Completion takes priority over the timeout on the same cycle.
          if (dram_ready) begin
            if (cmd_r_nw) begin
              rdata <= dram_rdata;
            end
            cnt   <= '0;
            state <= S_DONE;
          end else if (cnt == CNT_MAX) begin
            state <= S_ERROR;        // counter stops here, never wraps
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_ERROR;   // ERROR is terminal until reset
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops
  // dram_enable and the ready pulses immediately, without waiting for a clock.
  assign dram_enable = (state == S_BUSY);
  assign ready_0     = (state == S_DONE) && !last_grant;
  assign ready_1     = (state == S_DONE) &&  last_grant;
  assign error       = (state == S_ERROR);
  assign state_debug = state;
  assign dram_r_nw   = cmd_r_nw;
  assign dram_addr   = cmd_addr;
  assign dram_wdata  = cmd_wdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
//
// Directed bench for dram_arbiter (TIMEOUT = 4). Stimulus pushes the expected
// completion (requester index, rdata) into a queue; a monitor pops and checks
// it whenever a ready pulse appears. The DRAM model returns
// dram_addr ^ 32'hDEADBEFF, so address 0x10 reads back 0xDEADBEEF.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int          NUMBIT    = 32;
  localparam int          ADDR_SIZE = 32;
  localparam int          TIMEOUT   = 4;
  localparam logic [31:0] SALT      = 32'hDEADBEFF;

  logic                 clk;
  logic                 rst;
  logic                 en_0, en_1, r_nw_0, r_nw_1;
  logic [ADDR_SIZE-1:0] addr_0, addr_1;
  logic [NUMBIT-1:0]    wdata_0, wdata_1;
  logic                 ready_0, ready_1;
  logic [NUMBIT-1:0]    rdata;
  logic                 dram_enable, dram_r_nw;
  logic [ADDR_SIZE-1:0] dram_addr;
  logic [NUMBIT-1:0]    dram_wdata;
  logic [NUMBIT-1:0]    dram_rdata;
  logic                 dram_ready;
  logic                 error;
  logic [1:0]           state_debug;

  dram_arbiter #(
    .NUMBIT(NUMBIT), .ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .en_0(en_0), .r_nw_0(r_nw_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .en_1(en_1), .r_nw_1(r_nw_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ready_0(ready_0), .ready_1(ready_1), .rdata(rdata),
    .dram_enable(dram_enable), .dram_r_nw(dram_r_nw),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_ready(dram_ready),
    .error(error), .state_debug(state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dram_rdata = dram_addr ^ SALT;

  typedef struct {
    logic        idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (ready_0 || ready_1)) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {62'd0, ready_1, ready_0}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready_select", {62'd0, ready_1, ready_0}, e.idx ? 64'd2 : 64'd1);
        check("rdata", {32'd0, rdata}, {32'd0, e.data});
      end
    end
  end

  // One access by requester k; dram_ready is raised in BUSY cycle wait+1.
  // If poke is set, the other requester raises en during BUSY and drops it
  // before the FSM returns to IDLE, so it must never be granted.
  task automatic do_access(input bit k, input bit rnw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wait_cycles,
                           input bit poke);
    exp_t e;
    if (rnw) model_rdata = addr ^ SALT;
    e.idx  = k;
    e.data = model_rdata;
    exp_q.push_back(e);
    if (k) begin
      en_1 = 1'b1; r_nw_1 = rnw; addr_1 = addr; wdata_1 = wdata;
    end else begin
      en_0 = 1'b1; r_nw_0 = rnw; addr_0 = addr; wdata_0 = wdata;
    end
    tick();
    for (int i = 0; i <= wait_cycles; i++) begin
      check("busy_state", {62'd0, state_debug}, 64'd1);
      check("busy_enable", {63'd0, dram_enable}, 64'd1);
      check("busy_addr", {32'd0, dram_addr}, {32'd0, addr});
      check("busy_r_nw", {63'd0, dram_r_nw}, {63'd0, rnw});
      check("busy_wdata", {32'd0, dram_wdata}, {32'd0, wdata});
      if (i == 0 && poke) begin
        if (k) begin
          en_0 = 1'b1; addr_0 = 32'hBAD0; r_nw_0 = 1'b1;
        end else begin
          en_1 = 1'b1; addr_1 = 32'hBAD1; r_nw_1 = 1'b1;
        end
      end
      if (i == wait_cycles) dram_ready = 1'b1;
      tick();
    end
    dram_ready = 1'b0;
    en_0 = 1'b0;
    en_1 = 1'b0;
    check("done_state", {62'd0, state_debug}, 64'd2);
    check("done_enable", {63'd0, dram_enable}, 64'd0);
    check("done_addr_hold", {32'd0, dram_addr}, {32'd0, addr});
    check("done_error", {63'd0, error}, 64'd0);
    tick();
    check("idle_state", {62'd0, state_debug}, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; en_0 = 1'b0; en_1 = 1'b0; r_nw_0 = 1'b0; r_nw_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0; dram_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state", {62'd0, state_debug}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_enable", {63'd0, dram_enable}, 64'd0);
    check("rst_ready", {62'd0, ready_1, ready_0}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_addr", {32'd0, dram_addr}, 64'd0);

    // Tie: both requesting, immediate dram_ready; first edge after reset grants
    // CPU, then 0,1,0,1 at one completion every 3 cycles.
    r_nw_0 = 1'b1; addr_0 = 32'h200;
    r_nw_1 = 1'b1; addr_1 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      e.idx  = i[0];
      e.data = (i[0] ? 32'h300 : 32'h200) ^ SALT;
      exp_q.push_back(e);
    end
    model_rdata = 32'h300 ^ SALT;
    rst = 1'b1; en_0 = 1'b1; en_1 = 1'b1; dram_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("tie_state", {62'd0, state_debug},
            (i % 3 == 0) ? 64'd1 : (i % 3 == 1) ? 64'd2 : 64'd0);
      check("tie_enable", {63'd0, dram_enable}, (i % 3 == 0) ? 64'd1 : 64'd0);
      if (i == 10) begin
        en_0 = 1'b0; en_1 = 1'b0;
      end
    end
    dram_ready = 1'b0;
    check("tie_drained", exp_q.size(), 64'd0);

    // Loader write with a CPU request poked in during BUSY (must be ignored)
    do_access(1'b1, 1'b0, 32'h100, 32'h12345678, 1, 1'b1);
    check("write_rdata_kept", {32'd0, rdata}, {32'd0, 32'h300 ^ SALT});

    // Single CPU read, dram_ready after 2 BUSY cycles
    do_access(1'b0, 1'b1, 32'h10, 32'h0, 2, 1'b0);
    check("read_rdata", {32'd0, rdata}, {32'd0, 32'hDEADBEEF});

    // Boundary: dram_ready in the 4th BUSY cycle completes, no error
    do_access(1'b0, 1'b1, 32'h44, 32'h0, 3, 1'b0);

    // Timeout: no dram_ready, ERROR after 4 BUSY cycles
    en_0 = 1'b1; r_nw_0 = 1'b1; addr_0 = 32'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_busy", {62'd0, state_debug}, 64'd1);
    end
    tick();
    check("to_state", {62'd0, state_debug}, 64'd3);
    check("to_error", {63'd0, error}, 64'd1);
    check("to_enable", {63'd0, dram_enable}, 64'd0);
    repeat (3) tick();   // en_0 still high: ignored, error sticky
    check("to_sticky", {62'd0, state_debug}, 64'd3);
    check("to_ready", {62'd0, ready_1, ready_0}, 64'd0);
    en_0 = 1'b0;
    rst = 1'b0;
    #1;
    check("to_rst_error", {63'd0, error}, 64'd0);
    check("to_rst_state", {62'd0, state_debug}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of a BUSY cycle
    en_1 = 1'b1; r_nw_1 = 1'b1; addr_1 = 32'h400;
    tick();
    check("ar_busy", {63'd0, dram_enable}, 64'd1);
    en_1 = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_enable", {63'd0, dram_enable}, 64'd0);
    check("ar_state", {62'd0, state_debug}, 64'd0);
    check("ar_rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    check("ar_idle", {62'd0, state_debug}, 64'd0);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
